// File: rtl/spi_stim_master.sv
// SPI mode-0 stimulus master: shifts one MSB-first word of 1..MAXW bits to one of NCH targets.
// Request accepted only in IDLE; outputs are registered, first bit appears one cycle after acceptance.
module spi_stim_master #(
   parameter int NCH  = 2,
   parameter int MAXW = 80,
   parameter int DIV  = 2,
   localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1,
   localparam int LW  = $clog2(MAXW + 1)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [CW-1:0]   req_ch,
   input  logic [LW-1:0]   req_len,
   input  logic [MAXW-1:0] req_data,
   input  logic            abort,
   output logic            sclk,
   output logic            mosi,
   output logic [NCH-1:0]  ss_n,
   output logic            busy,
   output logic            done,
   output logic            err
);

   typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, HOLD} state_t;

   localparam logic [7:0] HALF = 8'(DIV - 1);

   state_t          state, state_nxt;
   logic [7:0]      hcnt, hcnt_nxt;
   logic [LW-1:0]   bcnt, bcnt_nxt;
   logic [MAXW-1:0] shreg, shreg_nxt;
   logic            sclk_nxt, mosi_nxt, done_nxt, err_nxt;
   logic [NCH-1:0]  ss_n_nxt;

   logic            req_bad;
   logic [MAXW-1:0] shreg_ld, shreg_shl;

   // Left-align the payload so the first bit to send always sits at the MSB.
   assign shreg_ld  = req_data << (LW'(MAXW) - req_len);
   assign shreg_shl = shreg << 1;
   assign req_bad   = (req_len == '0) || (req_len > LW'(MAXW)) || (32'(req_ch) >= 32'(NCH));

   assign req_ready = (state == IDLE);
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         hcnt  <= '0;
         bcnt  <= '0;
         shreg <= '0;
         sclk  <= 1'b0;
         mosi  <= 1'b0;
         ss_n  <= '1;
         done  <= 1'b0;
         err   <= 1'b0;
      end else begin
         state <= state_nxt;
         hcnt  <= hcnt_nxt;
         bcnt  <= bcnt_nxt;
         shreg <= shreg_nxt;
         sclk  <= sclk_nxt;
         mosi  <= mosi_nxt;
         ss_n  <= ss_n_nxt;
         done  <= done_nxt;
         err   <= err_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      hcnt_nxt  = hcnt;
      bcnt_nxt  = bcnt;
      shreg_nxt = shreg;
      sclk_nxt  = sclk;
      mosi_nxt  = mosi;
      ss_n_nxt  = ss_n;
      done_nxt  = 1'b0;
      err_nxt   = 1'b0;

      case (state)
         IDLE: begin
            sclk_nxt = 1'b0;
            mosi_nxt = 1'b0;
            ss_n_nxt = '1;
            hcnt_nxt = '0;
            bcnt_nxt = '0;
            if (req_valid) begin
               if (req_bad) begin
                  err_nxt = 1'b1;
               end else begin
                  state_nxt = SHIFT_LO;
                  hcnt_nxt  = HALF;
                  bcnt_nxt  = req_len - LW'(1);
                  shreg_nxt = shreg_ld;
                  mosi_nxt  = shreg_ld[MAXW-1];
                  ss_n_nxt  = ~(NCH'(1) << req_ch);
               end
            end
         end
         SHIFT_LO: begin
            if (hcnt == '0) begin
               state_nxt = SHIFT_HI;
               sclk_nxt  = 1'b1;
               hcnt_nxt  = HALF;
            end else begin
               hcnt_nxt = hcnt - 8'd1;
            end
         end
         SHIFT_HI: begin
            if (hcnt == '0) begin
               sclk_nxt = 1'b0;
               hcnt_nxt = HALF;
               // bcnt holds the index of the bit on the wire; zero means the word is finished.
               if (bcnt == '0) begin
                  state_nxt = HOLD;
                  mosi_nxt  = 1'b0;
               end else begin
                  state_nxt = SHIFT_LO;
                  bcnt_nxt  = bcnt - LW'(1);
                  shreg_nxt = shreg_shl;
                  mosi_nxt  = shreg_shl[MAXW-1];
               end
            end else begin
               hcnt_nxt = hcnt - 8'd1;
            end
         end
         HOLD: begin
            if (hcnt == '0) begin
               state_nxt = IDLE;
               ss_n_nxt  = '1;
               done_nxt  = 1'b1;
            end else begin
               hcnt_nxt = hcnt - 8'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase

      if (abort && (state != IDLE)) begin
         state_nxt = IDLE;
         hcnt_nxt  = '0;
         bcnt_nxt  = '0;
         sclk_nxt  = 1'b0;
         mosi_nxt  = 1'b0;
         ss_n_nxt  = '1;
         done_nxt  = 1'b0;
         err_nxt   = 1'b0;
      end
   end

endmodule

// File: tb/tb_spi_stim_master.sv
// Directed bench for spi_stim_master: main instance NCH=2/MAXW=80/DIV=2, plus an NCH=3 instance
// so an out-of-range channel index is representable on req_ch.
module tb_spi_stim_master;

   localparam int DV = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ch = 1'b0;
   logic [6:0]  req_len = '0;
   logic [79:0] req_data = '0;
   logic        abort = 1'b0;
   logic        req_ready, sclk, mosi, busy, done, err;
   logic [1:0]  ss_n;

   logic        req_valid3 = 1'b0;
   logic [1:0]  req_ch3 = '0;
   logic        req_ready3, sclk3, mosi3, busy3, done3, err3;
   logic [2:0]  ss_n3;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   spi_stim_master #(.NCH(2), .MAXW(80), .DIV(DV)) u_dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_ch(req_ch), .req_len(req_len), .req_data(req_data), .abort(abort),
      .sclk(sclk), .mosi(mosi), .ss_n(ss_n), .busy(busy), .done(done), .err(err));

   spi_stim_master #(.NCH(3), .MAXW(80), .DIV(DV)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_ready(req_ready3),
      .req_ch(req_ch3), .req_len(req_len), .req_data(req_data), .abort(1'b0),
      .sclk(sclk3), .mosi(mosi3), .ss_n(ss_n3), .busy(busy3), .done(done3), .err(err3));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Called at cycle A+1 of an accepted request; walks to A+T+DV+2 checking the full waveform.
   task automatic xfer(input string tag, input int len, input logic [79:0] data, input logic [1:0] ss_exp);
      int   t;
      int   rises;
      logic prev;
      t     = 2 * len * DV;
      rises = 0;
      prev  = 1'b0;
      for (int k = 1; k <= t + DV + 2; k++) begin
         if (k > 1) step();
         if (k <= t) begin
            chk({tag, "_sclk"}, 32'(sclk), 32'(((k - 1) % (2 * DV)) >= DV));
            chk({tag, "_mosi"}, 32'(mosi), 32'(data[len - 1 - (k - 1) / (2 * DV)]));
            chk({tag, "_ss"},   32'(ss_n), 32'(ss_exp));
            chk({tag, "_done"}, 32'(done), 32'd0);
         end else if (k <= t + DV) begin
            chk({tag, "_hold_sclk"}, 32'(sclk), 32'd0);
            chk({tag, "_hold_ss"},   32'(ss_n), 32'(ss_exp));
            chk({tag, "_hold_done"}, 32'(done), 32'd0);
         end else if (k == t + DV + 1) begin
            chk({tag, "_done"},     32'(done),      32'd1);
            chk({tag, "_end_ss"},   32'(ss_n),      32'd3);
            chk({tag, "_end_rdy"},  32'(req_ready), 32'd1);
            chk({tag, "_end_sclk"}, 32'(sclk),      32'd0);
            chk({tag, "_end_mosi"}, 32'(mosi),      32'd0);
         end else begin
            chk({tag, "_done_drop"}, 32'(done), 32'd0);
         end
         if (sclk && !prev) rises++;
         prev = sclk;
      end
      chk({tag, "_rises"}, 32'(rises), 32'(len));
   endtask

   initial begin
      // Asynchronous reset state, before any clock edge
      #1 rst_n = 1'b0;
      #1;
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_busy",  32'(busy),      32'd0);
      chk("rst_ss",    32'(ss_n),      32'd3);
      chk("rst_sclk",  32'(sclk),      32'd0);
      chk("rst_mosi",  32'(mosi),      32'd0);
      chk("rst_done",  32'(done),      32'd0);
      chk("rst_err",   32'(err),       32'd0);
      step(); step();
      rst_n = 1'b1;
      step();

      // Basic 8-bit transfer: ch1, 0xA5
      req_valid = 1'b1; req_ch = 1'b1; req_len = 7'd8; req_data = 80'hA5;
      step();
      req_valid = 1'b0;
      chk("t1_busy",  32'(busy),      32'd1);
      chk("t1_ready", 32'(req_ready), 32'd0);
      xfer("t1", 8, 80'hA5, 2'b01);

      // Rejected requests on the main instance
      req_valid = 1'b1; req_ch = 1'b0; req_len = 7'd0; req_data = 80'hFF;
      step();
      req_valid = 1'b0;
      chk("len0_err",  32'(err),  32'd1);
      chk("len0_ss",   32'(ss_n), 32'd3);
      chk("len0_busy", 32'(busy), 32'd0);
      chk("len0_done", 32'(done), 32'd0);
      step();
      chk("len0_err_drop", 32'(err),  32'd0);
      chk("len0_ss2",      32'(ss_n), 32'd3);
      req_valid = 1'b1; req_len = 7'd81;
      step();
      req_valid = 1'b0;
      chk("len81_err",  32'(err),  32'd1);
      chk("len81_ss",   32'(ss_n), 32'd3);
      chk("len81_sclk", 32'(sclk), 32'd0);
      chk("len81_done", 32'(done), 32'd0);
      step();
      chk("len81_err_drop", 32'(err),  32'd0);
      chk("len81_ss2",      32'(ss_n), 32'd3);

      // Out-of-range channel on the NCH=3 instance, then a valid one-bit transfer on ch2
      req_valid3 = 1'b1; req_ch3 = 2'd3; req_len = 7'd8; req_data = 80'h1;
      step();
      chk("ch3_err",  32'(err3),  32'd1);
      chk("ch3_ss",   32'(ss_n3), 32'd7);
      chk("ch3_busy", 32'(busy3), 32'd0);
      chk("ch3_done", 32'(done3), 32'd0);
      req_ch3 = 2'd2; req_len = 7'd1;
      step();
      req_valid3 = 1'b0;
      chk("ch2_ss",   32'(ss_n3), 32'd3);
      chk("ch2_err",  32'(err3),  32'd0);
      chk("ch2_mosi", 32'(mosi3), 32'd1);
      for (int i = 0; i < 5; i++) step();
      chk("ch2_pre_done", 32'(done3), 32'd0);
      step();
      chk("ch2_done",    32'(done3), 32'd1);
      chk("ch2_end_ss",  32'(ss_n3), 32'd7);

      // Back-to-back: 2-bit ch0 (b10) then 2-bit ch1 (b01), req_valid held high
      step();
      req_valid = 1'b1; req_ch = 1'b0; req_len = 7'd2; req_data = 80'h2;
      step();
      chk("b2b_a1_ss",   32'(ss_n), 32'd2);
      chk("b2b_a1_mosi", 32'(mosi), 32'd1);
      req_ch = 1'b1; req_data = 80'h1;
      for (int i = 0; i < 4; i++) step();
      chk("b2b_a5_mosi", 32'(mosi), 32'd0);
      for (int i = 0; i < 5; i++) step();
      chk("b2b_a10_ss",   32'(ss_n), 32'd2);
      chk("b2b_a10_done", 32'(done), 32'd0);
      step();
      chk("b2b_a11_done",  32'(done),      32'd1);
      chk("b2b_a11_ss",    32'(ss_n),      32'd3);
      chk("b2b_a11_ready", 32'(req_ready), 32'd1);
      step();
      req_valid = 1'b0;
      chk("b2b_a12_ss",   32'(ss_n), 32'd1);
      chk("b2b_a12_busy", 32'(busy), 32'd1);
      chk("b2b_a12_mosi", 32'(mosi), 32'd0);
      chk("b2b_a12_done", 32'(done), 32'd0);
      for (int i = 0; i < 9; i++) step();
      chk("b2b_a21_done", 32'(done), 32'd0);
      step();
      chk("b2b_a22_done", 32'(done), 32'd1);
      chk("b2b_a22_ss",   32'(ss_n), 32'd3);
      step();

      // Abort at A+10 of an 8-bit transfer
      req_valid = 1'b1; req_ch = 1'b1; req_len = 7'd8; req_data = 80'hA5;
      step();
      req_valid = 1'b0;
      for (int i = 0; i < 9; i++) step();
      chk("abt_a10_ss", 32'(ss_n), 32'd1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abt_ss",    32'(ss_n),      32'd3);
      chk("abt_sclk",  32'(sclk),      32'd0);
      chk("abt_mosi",  32'(mosi),      32'd0);
      chk("abt_ready", 32'(req_ready), 32'd1);
      chk("abt_done",  32'(done),      32'd0);
      begin
         int seen_done;
         seen_done = 0;
         for (int i = 0; i < 30; i++) begin
            step();
            if (done) seen_done++;
         end
         chk("abt_no_done", 32'(seen_done), 32'd0);
      end

      // Abort in IDLE must not block a simultaneous acceptance; held abort kills it next cycle
      abort = 1'b1; req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      chk("abt_idle_ss",   32'(ss_n), 32'd1);
      chk("abt_idle_busy", 32'(busy), 32'd1);
      step();
      abort = 1'b0;
      chk("abt2_ss",   32'(ss_n), 32'd3);
      chk("abt2_busy", 32'(busy), 32'd0);
      step();

      // Asynchronous reset during SHIFT_HI, then a full-width transfer
      req_valid = 1'b1; req_ch = 1'b0; req_len = 7'd8; req_data = 80'hA5;
      step();
      req_valid = 1'b0;
      step(); step();
      chk("rst_mid_sclk_hi", 32'(sclk), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_sclk",  32'(sclk),      32'd0);
      chk("rst_mid_ss",    32'(ss_n),      32'd3);
      chk("rst_mid_busy",  32'(busy),      32'd0);
      chk("rst_mid_ready", 32'(req_ready), 32'd1);
      step(); step();
      chk("rst_hold_done", 32'(done), 32'd0);
      rst_n = 1'b1;
      req_valid = 1'b1; req_ch = 1'b1; req_len = 7'd80;
      req_data = {16'hC3A5, 64'h0123_4567_89AB_CDEF};
      step();
      req_valid = 1'b0;
      chk("w80_busy", 32'(busy), 32'd1);
      xfer("w80", 80, {16'hC3A5, 64'h0123_4567_89AB_CDEF}, 2'b01);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/spi_stim_master.md
SPI_STIM_MASTER -- requirements
Module: spi_stim_master

Interface
REQ-001 The block SHALL have parameter NCH, default 2, meaning the number of independent SPI target channels (ss_n lines), range 1..8.
REQ-002 The block SHALL have parameter MAXW, default 80, meaning the maximum word length in bits per transaction.
REQ-003 The block SHALL have parameter DIV, default 2, meaning the clk cycles per SCLK half-period, range 1..255.
REQ-004 clk  in  1  sole clock; all state SHALL change on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous and active-low.
REQ-006 req_valid  in  1  transaction request.
REQ-007 req_ready  out  1  block can accept a request.
REQ-008 req_ch  in  clog2(NCH) (min 1)  target channel index.
REQ-009 req_len  in  clog2(MAXW+1)  number of bits to shift.
REQ-010 req_data  in  MAXW  payload; bit req_len-1 is sent first.
REQ-011 abort  in  1  synchronous transfer cancel.
REQ-012 sclk  out  1  shared serial clock, idle low.
REQ-013 mosi  out  1  shared serial data.
REQ-014 ss_n  out  NCH  per-channel active-low select.
REQ-015 busy  out  1  transaction in progress.
REQ-016 done  out  1  one-cycle pulse on normal completion.
REQ-017 err  out  1  one-cycle pulse on a rejected request.

Function
REQ-018 The block SHALL implement states IDLE, SHIFT_LO, SHIFT_HI, HOLD; req_ready SHALL be 1 only in IDLE; busy SHALL be 1 in every state other than IDLE.
REQ-019 A request SHALL be accepted on a cycle A with req_valid=1 and req_ready=1; req_ch, req_len and req_data SHALL be captured at A and ignored afterwards.
REQ-020 A request with req_len=0, req_len>MAXW, or req_ch>=NCH SHALL produce err=1 in cycle A+1, with the block remaining in IDLE, all ss_n staying high, and sclk/mosi unchanged.
REQ-021 For a valid request, from cycle A+1 ss_n[req_ch] SHALL be 0, all other ss_n SHALL be 1, and the block SHALL enter SHIFT_LO with mosi = bit req_len-1.
REQ-022 Each bit SHALL occupy DIV cycles of SHIFT_LO (sclk=0) followed by DIV cycles of SHIFT_HI (sclk=1); mosi SHALL be constant across both phases (SPI mode 0, MSB first).
REQ-023 On leaving SHIFT_HI, mosi SHALL present the next lower bit; after bit 0 the block SHALL enter HOLD for DIV cycles with sclk=0 and ss_n still asserted.
REQ-024 Leaving HOLD, at cycle A+(2*req_len+1)*DIV+1, ss_n SHALL be all 1, done SHALL be 1 for exactly that cycle, state SHALL be IDLE, and req_ready SHALL be 1.
REQ-025 A request presented in the same cycle as done SHALL be accepted (back-to-back); ss_n SHALL be high for at least that one cycle between transactions.
REQ-026 The half-period counter SHALL count DIV-1 down to 0; the bit counter SHALL decrement per SHIFT_HI exit and SHALL never wrap below 0.
REQ-027 abort=1 in any non-IDLE state SHALL, next cycle, force sclk=0, mosi=0, all ss_n=1, state IDLE, with no done or err pulse; abort in IDLE SHALL have no effect and SHALL NOT block a simultaneous acceptance.
REQ-028 In IDLE, mosi SHALL be 0 and sclk SHALL be 0.

Reset
REQ-029 When rst_n=0, the block SHALL immediately (without waiting for clk) force state IDLE, sclk=0, mosi=0, ss_n all 1, busy=0, done=0, err=0, req_ready=1, counters 0.
REQ-030 When reset is asserted mid-transaction, the transaction SHALL be discarded, with no done pulse after release; the first clk edge after rst_n rises SHALL be able to accept a request.

Verification
REQ-031 The bench SHALL check: DIV=2, ch=1, len=8, data=0xA5 accepted at A -> ss_n=2'b01 from A+1; sclk rising edges at A+3,7,...,31; mosi sequence 1,0,1,0,0,1,0,1; done at A+35.
REQ-032 The bench SHALL check: len=0, then ch=NCH, then len=MAXW+1 -> err pulse at A+1 each time, ss_n never leaves all-1, done never asserted.
REQ-033 The bench SHALL check: two requests back-to-back with req_valid held high -> second accepted on the done cycle, ss_n high exactly one cycle between transactions.
REQ-034 The bench SHALL check: abort at A+10 of an 8-bit transfer -> at A+11 ss_n all 1, sclk 0, req_ready 1, and no done.
REQ-035 The bench SHALL check: rst_n driven low between clk edges during SHIFT_HI -> sclk 0 and ss_n all 1 before the next edge; after release, a len=MAXW=80 transfer completes with 80 rising sclk edges and done at A+(161*DIV)+1.
